// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and limits for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic arb_owner_t;

  localparam int MAX_BURST_LIMIT = 255;

  // Wide enough to hold MAX_BURST_LIMIT-1
  localparam int BEAT_CNT_W = 8;

endpackage

// File: rtl/wb_arb2_beat_cnt.sv
// arb_beat_cnt: counts acks taken by the current bus owner and flags the
// beat on which the owner becomes preemptible.
module arb_beat_cnt
  import wb_arb_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  input  logic sat_en,
  output logic terminal
);

  localparam logic [BEAT_CNT_W-1:0] LAST = BEAT_CNT_W'(MAX_BURST - 1);

  logic [BEAT_CNT_W-1:0] cnt;

  // Clear on a new tenure, otherwise count acks and hold at the last beat
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      if (cnt == LAST) begin
        cnt <= sat_en ? LAST : '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign terminal = (cnt == LAST);

endmodule

// File: rtl/wb_arb2.sv
// wb_arb2: two-master, one-slave arbiter for classic Wishbone (frame buffer
// path). Registered grant, round-robin ties, bounded-burst preemption; the
// grant only moves after an ack or when the owner releases cyc.
// Define WB_ARB_M0_PRIO_EN to give master 0 fixed priority: it wins ties,
// is never preempted, and the last-owner register disappears.
module wb_arb2
  import wb_arb_pkg::*;
#(
  parameter int ADR_W     = 32,
  parameter int DAT_W     = 32,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m0_cyc,
  input  logic               m0_stb,
  input  logic               m0_we,
  input  logic [ADR_W-1:0]   m0_adr,
  input  logic [DAT_W-1:0]   m0_dat_w,
  input  logic [DAT_W/8-1:0] m0_sel,
  output logic               m0_ack,
  output logic [DAT_W-1:0]   m0_dat_r,
  output logic               m0_gnt,
  input  logic               m1_cyc,
  input  logic               m1_stb,
  input  logic               m1_we,
  input  logic [ADR_W-1:0]   m1_adr,
  input  logic [DAT_W-1:0]   m1_dat_w,
  input  logic [DAT_W/8-1:0] m1_sel,
  output logic               m1_ack,
  output logic [DAT_W-1:0]   m1_dat_r,
  output logic               m1_gnt,
  output logic               s_cyc,
  output logic               s_stb,
  output logic               s_we,
  output logic [ADR_W-1:0]   s_adr,
  output logic [DAT_W-1:0]   s_dat_w,
  output logic [DAT_W/8-1:0] s_sel,
  input  logic               s_ack,
  input  logic [DAT_W-1:0]   s_dat_r
);

  arb_state_t state;
  logic       owner_cyc;
  logic       other_cyc;
  logic       tie_to_m0;
  logic       can_preempt;
  logic       preempt;
  logic       terminal;

`ifdef WB_ARB_M0_PRIO_EN
  assign tie_to_m0   = 1'b1;
  assign can_preempt = (state == OWN1);
`else
  arb_owner_t last_owner;

  // Remember the most recent owner; it is only consulted in IDLE, so
  // following the registered state one cycle behind is early enough
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= 1'b1;
    end else if (state == OWN0) begin
      last_owner <= 1'b0;
    end else if (state == OWN1) begin
      last_owner <= 1'b1;
    end
  end

  assign tie_to_m0   = last_owner;
  assign can_preempt = (state != IDLE);
`endif

  // Pick out the owner's cyc and the competing master's cyc
  always_comb begin
    owner_cyc = 1'b0;
    other_cyc = 1'b0;
    case (state)
      OWN0: begin
        owner_cyc = m0_cyc;
        other_cyc = m1_cyc;
      end
      OWN1: begin
        owner_cyc = m1_cyc;
        other_cyc = m0_cyc;
      end
      default: ;
    endcase
  end

  assign preempt = owner_cyc & other_cyc & s_ack & terminal & can_preempt;

  arb_beat_cnt #(
    .MAX_BURST (MAX_BURST)
  ) u_beat_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (~owner_cyc | preempt),
    .inc      (s_ack & owner_cyc),
    .sat_en   (~preempt),
    .terminal (terminal)
  );

  // Grant FSM: moves on IDLE requests, owner release, or a preempting ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc && (!m1_cyc || tie_to_m0)) begin
            state <= OWN0;
          end else if (m1_cyc) begin
            state <= OWN1;
          end
        end
        OWN0: begin
          if (!m0_cyc) begin
            state <= m1_cyc ? OWN1 : IDLE;
          end else if (preempt) begin
            state <= OWN1;
          end
        end
        OWN1: begin
          if (!m1_cyc) begin
            state <= m0_cyc ? OWN0 : IDLE;
          end else if (preempt) begin
            state <= OWN0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m0_gnt = (state == OWN0);
  assign m1_gnt = (state == OWN1);

  // Route the owner's bus signals to the slave; IDLE drives everything low
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    case (state)
      OWN0: begin
        s_cyc   = m0_cyc;
        s_stb   = m0_stb & m0_cyc;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_dat_w = m0_dat_w;
        s_sel   = m0_sel;
      end
      OWN1: begin
        s_cyc   = m1_cyc;
        s_stb   = m1_stb & m1_cyc;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_dat_w = m1_dat_w;
        s_sel   = m1_sel;
      end
      default: ;
    endcase
  end

  // A reset cycle aborts the transfer, so a late slave ack is swallowed
  assign m0_ack   = s_ack & (state == OWN0) & ~reset;
  assign m1_ack   = s_ack & (state == OWN1) & ~reset;
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: randomized bench for wb_arb2 with a tenure-level grant model
// and a per-master scoreboard of issued beats.
module tb_wb_arb2;

  localparam int ADR_W      = 32;
  localparam int DAT_W      = 32;
  localparam int SEL_W      = DAT_W / 8;
  localparam int MAX_BURST  = 4;
  localparam int NUM_CYCLES = 4000;
`ifdef WB_ARB_M0_PRIO_EN
  localparam bit M0_PRIO = 1'b1;
`else
  localparam bit M0_PRIO = 1'b0;
`endif

  typedef struct {
    logic [ADR_W-1:0] adr;
    logic             we;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
  } beat_t;

  logic clk = 1'b0;
  logic reset;

  logic             mc[2];
  logic             ms[2];
  logic             mw[2];
  logic [ADR_W-1:0] ma[2];
  logic [DAT_W-1:0] md[2];
  logic [SEL_W-1:0] msel[2];

  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [ADR_W-1:0] m0_adr, m1_adr;
  logic [DAT_W-1:0] m0_dat_w, m1_dat_w;
  logic [SEL_W-1:0] m0_sel, m1_sel;
  logic m0_ack, m1_ack, m0_gnt, m1_gnt;
  logic [DAT_W-1:0] m0_dat_r, m1_dat_r;
  logic s_cyc, s_stb, s_we, s_ack;
  logic [ADR_W-1:0] s_adr;
  logic [DAT_W-1:0] s_dat_w, s_dat_r;
  logic [SEL_W-1:0] s_sel;

  assign m0_cyc = mc[0];  assign m0_stb = ms[0];  assign m0_we = mw[0];
  assign m0_adr = ma[0];  assign m0_dat_w = md[0]; assign m0_sel = msel[0];
  assign m1_cyc = mc[1];  assign m1_stb = ms[1];  assign m1_we = mw[1];
  assign m1_adr = ma[1];  assign m1_dat_w = md[1]; assign m1_sel = msel[1];

  wb_arb2 #(
    .ADR_W     (ADR_W),
    .DAT_W     (DAT_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_cyc   (m0_cyc),
    .m0_stb   (m0_stb),
    .m0_we    (m0_we),
    .m0_adr   (m0_adr),
    .m0_dat_w (m0_dat_w),
    .m0_sel   (m0_sel),
    .m0_ack   (m0_ack),
    .m0_dat_r (m0_dat_r),
    .m0_gnt   (m0_gnt),
    .m1_cyc   (m1_cyc),
    .m1_stb   (m1_stb),
    .m1_we    (m1_we),
    .m1_adr   (m1_adr),
    .m1_dat_w (m1_dat_w),
    .m1_sel   (m1_sel),
    .m1_ack   (m1_ack),
    .m1_dat_r (m1_dat_r),
    .m1_gnt   (m1_gnt),
    .s_cyc    (s_cyc),
    .s_stb    (s_stb),
    .s_we     (s_we),
    .s_adr    (s_adr),
    .s_dat_w  (s_dat_w),
    .s_sel    (s_sel),
    .s_ack    (s_ack),
    .s_dat_r  (s_dat_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  beat_t exp_q0[$];
  beat_t exp_q1[$];
  int    acks[2];

  int               remaining[2];
  logic [ADR_W-1:0] next_adr[2];
  logic             ack_seen[2];
  int               slave_wait = 0;
  bit               rand_phase = 1'b0;
  int               dir_step = 0;

  // Reference model: who owns the bus, who owned it last, acks this tenure
  int owner = -1;
  int last  = 1;
  int taken = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issueBeat(input int m);
    beat_t b;
    ms[m]   = 1'b1;
    mw[m]   = 1'($urandom_range(0, 1));
    ma[m]   = next_adr[m];
    md[m]   = $urandom;
    msel[m] = SEL_W'($urandom);
    next_adr[m] = next_adr[m] + 4;
    b.adr = ma[m];
    b.we  = mw[m];
    b.dat = md[m];
    b.sel = msel[m];
    if (m == 0) exp_q0.push_back(b);
    else        exp_q1.push_back(b);
  endtask

  task automatic startBurst(input int m, input int len, input logic [ADR_W-1:0] base);
    mc[m]        = 1'b1;
    remaining[m] = len;
    next_adr[m]  = base;
    issueBeat(m);
  endtask

  // Drive reset, directed openings, then random master traffic
  task automatic applyStimulus(input int cyc);
    reset = (cyc == 0) || (rand_phase && $urandom_range(0, 299) == 0);
    if (cyc == 1) begin
      startBurst(0, 3, 32'h0000_1000);
      startBurst(1, 3, 32'h0000_2000);
    end else if (cyc > 1 && dir_step == 0 && !mc[0] && !mc[1]) begin
      startBurst(1, 4, 32'h0000_0100);
      dir_step = 1;
    end else if (dir_step == 1 && !mc[0] && !mc[1]) begin
      dir_step   = 2;
      rand_phase = 1'b1;
    end
    for (int m = 0; m < 2; m++) begin
      if (mc[m]) begin
        if (ms[m] && ack_seen[m]) begin
          ms[m] = 1'b0;
          remaining[m]--;
        end
        if (!ms[m]) begin
          if (remaining[m] == 0) mc[m] = 1'b0;
          else if ($urandom_range(0, 3) != 0) issueBeat(m);
        end
      end else if (rand_phase && $urandom_range(0, 7) == 0) begin
        startBurst(m, $urandom_range(1, 12), $urandom & 32'hFFFF_FFFC);
      end
    end
  endtask

  task automatic driveSlave();
    if (s_stb === 1'b1) begin
      if (slave_wait == 0) begin
        s_ack      = 1'b1;
        slave_wait = $urandom_range(0, 2);
      end else begin
        s_ack = 1'b0;
        slave_wait--;
      end
    end else begin
      s_ack = 1'b0;
    end
    s_dat_r = $urandom;
  endtask

  task automatic checkCycle();
    logic             e_cyc, e_stb, e_we;
    logic [ADR_W-1:0] e_adr;
    logic [DAT_W-1:0] e_dat;
    logic [SEL_W-1:0] e_sel;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
    if (owner >= 0) begin
      e_cyc = mc[owner];
      e_stb = mc[owner] & ms[owner];
      e_we  = mw[owner];
      e_adr = ma[owner];
      e_dat = md[owner];
      e_sel = msel[owner];
    end
    checkOutput("grant", {62'd0, m1_gnt, m0_gnt}, {62'd0, owner == 1, owner == 0});
    checkOutput("slave_ctl", {57'd0, s_cyc, s_stb, s_we, s_sel}, {57'd0, e_cyc, e_stb, e_we, e_sel});
    checkOutput("slave_adr_dat", {s_adr, s_dat_w}, {e_adr, e_dat});
    checkOutput("ack_route", {62'd0, m1_ack, m0_ack},
                {62'd0, s_ack && owner == 1 && !reset, s_ack && owner == 0 && !reset});
  endtask

  // Advance the model by the edge that follows this sample point
  task automatic updateModel();
    int o;
    int nxt;
    if (reset) begin
      owner = -1;
      last  = 1;
      taken = 0;
      return;
    end
    if (owner < 0) begin
      if (mc[0] && mc[1]) nxt = M0_PRIO ? 0 : 1 - last;
      else if (mc[0])     nxt = 0;
      else if (mc[1])     nxt = 1;
      else                nxt = -1;
      if (nxt >= 0) begin
        owner = nxt;
        last  = nxt;
        taken = 0;
      end
    end else begin
      o = owner;
      if (!mc[o]) begin
        if (mc[1-o]) begin
          owner = 1 - o;
          last  = owner;
          taken = 0;
        end else begin
          owner = -1;
        end
      end else if (s_ack) begin
        if (mc[1-o] && taken >= MAX_BURST - 1 && (!M0_PRIO || o == 1)) begin
          owner = 1 - o;
          last  = owner;
          taken = 0;
        end else begin
          taken++;
        end
      end
    end
  endtask

  task automatic scoreboardPop(input int m);
    beat_t b;
    if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL sb_underflow: master %0d got ack with no beat outstanding at %0t", m, $time);
      return;
    end
    if (m == 0) b = exp_q0.pop_front();
    else        b = exp_q1.pop_front();
    acks[m]++;
    checkOutput("sb_beat", {s_adr, s_dat_w}, {b.adr, b.dat});
    checkOutput("sb_ctl", {59'd0, s_we, s_sel}, {59'd0, b.we, b.sel});
    checkOutput("sb_rdata", {(m == 0) ? m0_dat_r : m1_dat_r, 32'd0}, {s_dat_r, 32'd0});
  endtask

  // Scoreboard monitor: retire a beat whenever the DUT forwards an ack
  always @(negedge clk) begin
    if (m0_ack === 1'b1) scoreboardPop(0);
    if (m1_ack === 1'b1) scoreboardPop(1);
  end

  initial begin
    reset = 1'b1;
    s_ack = 1'b0;
    s_dat_r = '0;
    acks[0] = 0;
    acks[1] = 0;
    for (int m = 0; m < 2; m++) begin
      mc[m] = 1'b0; ms[m] = 1'b0; mw[m] = 1'b0;
      ma[m] = '0; md[m] = '0; msel[m] = '0;
      remaining[m] = 0; next_adr[m] = '0; ack_seen[m] = 1'b0;
    end
    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      @(posedge clk);
      #1;
      applyStimulus(cyc);
      #1;
      driveSlave();
      @(negedge clk);
      checkCycle();
      ack_seen[0] = (m0_ack === 1'b1);
      ack_seen[1] = (m1_ack === 1'b1);
      updateModel();
    end
    checkOutput("m0_progress", {63'd0, acks[0] > 0}, 64'd1);
    checkOutput("m1_progress", {63'd0, acks[1] > 0}, 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arb2.md
Name: wb_arb2

Overview:
- Two-master to one-slave arbiter for the classic (non-pipelined) Wishbone bus that reaches the SDRAM frame buffer.
- Master 0 is the video-read FSM and master 1 is the pixel-write FSM; the slave is the memory bridge.
- Replaces ad hoc flag handshakes between the two FSMs with registered grant, round-robin fairness and bounded-burst preemption.
- The grant changes only on a beat boundary, which is the cycle after an ack.

Parameters:
- ADR_W, 32, address width.
- DAT_W, 32, data width; the SEL width is DAT_W/8.
- MAX_BURST, 16, acks an owner may take while the other master requests; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle, strobe, write enable
- m0_adr  in  ADR_W  master 0 address
- m0_dat_w  in  DAT_W  master 0 write data
- m0_sel  in  DAT_W/8  master 0 byte select
- m0_ack  out  1  master 0 acknowledge
- m0_dat_r  out  DAT_W  master 0 read data
- m0_gnt  out  1  master 0 currently owns the bus
- m1_*  same set as m0_*, for master 1
- s_cyc, s_stb, s_we  out  1 each  slave cycle, strobe, write enable
- s_adr  out  ADR_W  slave address
- s_dat_w  out  DAT_W  slave write data
- s_sel  out  DAT_W/8  slave byte select
- s_ack  in  1  slave acknowledge
- s_dat_r  in  DAT_W  slave read data

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Reset state:
  - state = IDLE, last_owner = 1, beat_cnt = 0.
  - All outputs are 0 the cycle after reset is sampled high.
  - Reset asserted mid-transfer aborts it: s_cyc drops, and any pending ack in that cycle is not forwarded.
- States: IDLE, OWN0, OWN1. Grant and state are registered; grant outputs are decoded from state.
- Slave mux (combinational from state):
  - OWNx: s_cyc = mx_cyc, s_stb = mx_stb & mx_cyc; s_we, s_adr, s_dat_w, s_sel come from mx.
  - IDLE: all s_* outputs are 0.
- Ack/data return:
  - mx_ack = s_ack & (state == OWNx).
  - mx_dat_r = s_dat_r, unconditionally.
  - A non-owner never sees ack; its stb simply stalls.
- IDLE transitions:
  - Only m0_cyc high -> OWN0. Only m1_cyc high -> OWN1.
  - Both high -> the master that is not last_owner.
  - Neither -> stay in IDLE.
  - Entering OWNx sets last_owner = x and clears beat_cnt.
- OWNx transitions:
  - mx_cyc low: if the other cyc is high -> OWN(other) directly, no IDLE cycle; else -> IDLE.
  - Ack with beat_cnt == MAX_BURST-1 and the other cyc high (preempt) -> OWN(other). The owner's next stb waits until it regains the grant.
  - Ack otherwise: beat_cnt += 1. beat_cnt saturates at MAX_BURST-1 while the other cyc is low.
- Handover latency: one cycle from the deciding edge to the new owner's strobe appearing on s_stb.
- Simultaneous ack and owner cyc drop -> the cyc-drop rule applies.
- No combinational path from m*_cyc to m*_gnt.

Optional Feature:
- WB_ARB_M0_PRIO_EN defined:
  - IDLE ties always go to m0.
  - m0 is never preempted; only m1 is preempted by a pending m0_cyc after MAX_BURST acks.
  - The last_owner register is removed.
- Undefined: symmetric round-robin as above.

Decomposition:
- Package wb_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, OWN0, OWN1};
  - typedef logic arb_owner_t;
  - localparam MAX_BURST_LIMIT = 255.
- Sub-module arb_beat_cnt:
  - Inputs: clear, inc, sat_en.
  - Output: terminal = (cnt == MAX_BURST-1).
  - Instantiated once.

Test Plan:
- Reset mid-transfer: m0 owns and is mid-beat, assert reset for 1 cycle -> next cycle s_cyc = 0, m0_gnt = 0, no m0_ack; after reset with m0 still requesting -> OWN0 one cycle later.
- Single master: m1 alone, 4 writes to 0x100..0x10C with slave ack after 1 wait cycle -> 4 m1_ack, s_adr matches each beat, m0_ack stays 0, IDLE after m1_cyc drops.
- Tie round-robin: m0_cyc and m1_cyc rise in the same cycle from reset -> OWN0 granted (last_owner = 1). Next tie -> OWN1.
- Preemption: MAX_BURST = 4, m1 owns and streams, m0_cyc rises at beat 1 -> exactly 4 m1_ack, then m0_gnt one cycle after the 4th ack; m1 resumes after m0_cyc drops.
- Handover on cyc drop: m0 drops cyc with m1 waiting -> m1_gnt on the next edge, no IDLE cycle, s_stb follows m1_stb.
- Priority build (WB_ARB_M0_PRIO_EN): m0 streams 40 beats with m1 waiting -> no preemption of m0, 40 m0_ack, then OWN1.
